// File: rtl/bcd_down_count.sv
// Cascadable BCD down-counter, DIGITS decimal digits with sync load and async reset.
// Define BCD_DOWN_COUNT_HOLD_EN to hold at all-zero instead of wrapping to all-9s.
module bcd_down_count #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                r,
  input  logic                en,
  input  logic                bin,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                bout,
  output logic                zero
);

  function automatic logic [3:0] sat_digit(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Non-BCD codes are unreachable; mapping them to 9 keeps the digit legal regardless.
  function automatic logic [3:0] dec_digit(input logic [3:0] v);
    return ((v == 4'd0) || (v > 4'd9)) ? 4'd9 : v - 4'd1;
  endfunction

  logic                dec_req;
  logic                term_hold;
  logic [DIGITS-1:0]   digit_zero;
  logic [DIGITS-1:0]   step;

  assign dec_req = en & bin & ~load;
  assign zero    = &digit_zero;
  assign bout    = dec_req & zero;

`ifdef BCD_DOWN_COUNT_HOLD_EN
  assign term_hold = zero;
`else
  assign term_hold = 1'b0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] cnt;

    assign digit_zero[k] = (cnt == 4'd0);

    // A digit steps when a decrement is requested and every lower digit is at 0.
    if (k == 0) begin : g_lsd
      assign step[k] = dec_req & ~term_hold;
    end else begin : g_upper
      assign step[k] = dec_req & ~term_hold & (&digit_zero[k-1:0]);
    end

    always_ff @(posedge clk or posedge r) begin
      if (r) begin
        cnt <= 4'd0;
      end else if (load) begin
        cnt <= sat_digit(d[4*k +: 4]);
      end else if (step[k]) begin
        cnt <= dec_digit(cnt);
      end
    end

    assign q[4*k +: 4] = cnt;
  end

endmodule

// File: tb/tb_bcd_down_count.sv
// Bench for bcd_down_count: integer reference model, per-cycle compare, directed + random stimulus.
module tb_bcd_down_count;

`ifdef BCD_DOWN_COUNT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       en = 1'b0, bin = 1'b0, load = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       bout, zero;

  logic        c_en = 1'b0, c_load = 1'b0;
  logic [15:0] c_d = 16'h0000;
  logic [7:0]  lo_q, hi_q;
  logic        lo_bout, lo_zero, hi_bout, hi_zero;

  int checks = 0;
  int passes = 0;

  int m_val = 0;
  int m_lo = 0;
  int m_hi = 0;

  always #5 clk = ~clk;

  bcd_down_count #(.DIGITS(2)) dut (
    .clk(clk), .r(r), .en(en), .bin(bin), .load(load), .d(d),
    .q(q), .bout(bout), .zero(zero)
  );

  bcd_down_count #(.DIGITS(2)) c_lo (
    .clk(clk), .r(r), .en(c_en), .bin(1'b1), .load(c_load), .d(c_d[7:0]),
    .q(lo_q), .bout(lo_bout), .zero(lo_zero)
  );

  bcd_down_count #(.DIGITS(2)) c_hi (
    .clk(clk), .r(r), .en(c_en), .bin(lo_bout), .load(c_load), .d(c_d[15:8]),
    .q(hi_q), .bout(hi_bout), .zero(hi_zero)
  );

  function automatic int sat_val(input logic [7:0] dv);
    int h, l;
    h = (dv[7:4] > 4'd9) ? 9 : int'(dv[7:4]);
    l = (dv[3:0] > 4'd9) ? 9 : int'(dv[3:0]);
    return h * 10 + l;
  endfunction

  function automatic logic [7:0] enc(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int next_val(input int v, input bit e, input bit b, input bit l,
                                  input logic [7:0] dv);
    if (l) return sat_val(dv);
    if (e && b) begin
      if (v == 0) return HOLD ? 0 : 99;
      return v - 1;
    end
    return v;
  endfunction

  // Reference model: plain decimal values, async cleared by r.
  always @(posedge clk or posedge r) begin
    if (r) begin
      m_val = 0;
      m_lo  = 0;
      m_hi  = 0;
    end else begin
      bit lob;
      lob   = c_en && !c_load && (m_lo == 0);
      m_val = next_val(m_val, en, bin, load, d);
      m_hi  = next_val(m_hi, c_en, lob, c_load, c_d[15:8]);
      m_lo  = next_val(m_lo, c_en, 1'b1, c_load, c_d[7:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    bit lob;
    lob = c_en && !c_load && (m_lo == 0);
    check("model_q", 32'(q), 32'(enc(m_val)));
    check("model_zero", 32'(zero), 32'(m_val == 0));
    check("model_bout", 32'(bout), 32'(en && bin && !load && (m_val == 0)));
    check("model_cascade_q", 32'({hi_q, lo_q}), 32'({enc(m_hi), enc(m_lo)}));
    check("model_lo_bout", 32'(lo_bout), 32'(lob));
    check("model_hi_bout", 32'(hi_bout), 32'(c_en && lob && !c_load && (m_hi == 0)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; d = v;
    tick();
    load = 1'b0;
  endtask

  logic [7:0] exp_seq [6];

  initial begin
    exp_seq = '{8'h24, 8'h23, 8'h22, 8'h21, 8'h20, 8'h19};

    // Reset state: zero forced, bout = en & bin & ~load
    en = 1'b1; bin = 1'b1;
    #3;
    check("reset_q", 32'(q), 32'h00);
    check("reset_zero", 32'(zero), 32'h1);
    check("reset_bout", 32'(bout), 32'h1);
    en = 1'b0; bin = 1'b0;
    tick();
    r = 1'b0;
    tick();

    // Async reset mid-cycle from 37
    do_load(8'h37);
    check("load_37", 32'(q), 32'h37);
    #1 r = 1'b1;
    #1;
    check("async_reset_q", 32'(q), 32'h00);
    check("async_reset_zero", 32'(zero), 32'h1);
    tick();
    r = 1'b0;

    // Load 25 and count down six cycles
    do_load(8'h25);
    check("load_25", 32'(q), 32'h25);
    en = 1'b1; bin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("count_q", 32'(q), 32'(exp_seq[i]));
      check("count_bout", 32'(bout), 32'h0);
    end

    // Zero boundary
    en = 1'b0;
    do_load(8'h01);
    en = 1'b1;
    tick();
    check("boundary_q", 32'(q), 32'h00);
    check("boundary_zero", 32'(zero), 32'h1);
    check("boundary_bout", 32'(bout), 32'h1);
    tick();
    check("boundary_wrap", 32'(q), HOLD ? 32'h00 : 32'h99);
    en = 1'b0;

    // Illegal digits saturate to 9
    do_load(8'hB7);
    check("load_B7", 32'(q), 32'h97);
    do_load(8'hFF);
    check("load_FF", 32'(q), 32'h99);

    // Load priority over decrement at zero
    do_load(8'h00);
    en = 1'b1; bin = 1'b1; load = 1'b1; d = 8'h42;
    #1;
    check("prio_bout", 32'(bout), 32'h0);
    tick();
    check("prio_q", 32'(q), 32'h42);
    load = 1'b0;

    // Hold paths
    en = 1'b1; bin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_bin0_q", 32'(q), 32'h42);
      check("hold_bin0_bout", 32'(bout), 32'h0);
    end
    en = 1'b0; bin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_en0_q", 32'(q), 32'h42);
      check("hold_en0_bout", 32'(bout), 32'h0);
    end

    // Cascade: 1000 -> 0999 in one edge
    c_load = 1'b1; c_d = 16'h1000;
    tick();
    c_load = 1'b0;
    check("cascade_load", 32'({hi_q, lo_q}), 32'h1000);
    c_en = 1'b1;
    #1;
    check("cascade_lo_bout", 32'(lo_bout), 32'h1);
    tick();
    check("cascade_step", 32'({hi_q, lo_q}), HOLD ? 32'h0900 : 32'h0999);
    c_en = 1'b0;

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      en     = 1'($urandom_range(0, 3) != 0);
      bin    = 1'($urandom_range(0, 3) != 0);
      load   = 1'($urandom_range(0, 9) == 0);
      d      = 8'($urandom);
      c_en   = 1'($urandom_range(0, 3) != 0);
      c_load = 1'($urandom_range(0, 19) == 0);
      c_d    = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1 r = 1'b1;
        #1;
        check("rand_async_reset", 32'(q), 32'h00);
        tick();
        r = 1'b0;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
